// File: rtl/mem_req_ctrl.sv
// Request/response front-end for a single-port synchronous memory cell.
// Accepts one valid/ready request at a time, range-checks the address, drives
// registered memory port signals, absorbs the 1-cycle read latency and returns
// read data on a valid/ready response channel.
module mem_req_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_SIZE  = 1024
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  // Request channel
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_write_in,
  input  logic [DATA_WIDTH-1:0] req_addr_in,
  input  logic [DATA_WIDTH-1:0] req_data_in,
  // Response channel
  output logic                  rsp_valid_out,
  input  logic                  rsp_ready_in,
  output logic [DATA_WIDTH-1:0] rsp_data_out,
  output logic                  rsp_err_out,
  output logic                  err_sticky_out,
  // Memory port
  output logic                  mem_read_write_out,
  output logic [DATA_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdIssue,
    StRdCapture,
    StRsp
  } state_e;

  localparam logic [DATA_WIDTH-1:0] AddrLimit = DATA_WIDTH'(DATA_SIZE);

  state_e                  state_q;
  logic                    ready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_err_q;
  logic                    err_sticky_q;
  logic                    mem_rw_q;
  logic [DATA_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  // Marks a read that failed the range check and is waiting to respond.
  logic                    rd_err_q;

  logic                    accept;
  logic                    addr_oor;

  // Request handshake and unsigned full-width range check.
  always_comb begin
    accept   = req_valid_in && ready_q;
    addr_oor = (req_addr_in >= AddrLimit);
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (req_write_in) begin
              if (addr_oor) begin
                // Dropped write: memory strobe stays low, stay ready.
                err_sticky_q <= 1'b1;
                ready_q      <= 1'b1;
              end else begin
                mem_rw_q   <= 1'b1;
                mem_addr_q <= req_addr_in;
                mem_data_q <= req_data_in;
                ready_q    <= 1'b0;
                state_q    <= StWr;
              end
            end else if (addr_oor) begin
              // Skip the issue cycle so the error response lands one edge after accept
              // without the memory address ever changing.
              rd_err_q <= 1'b1;
              ready_q  <= 1'b0;
              state_q  <= StRdCapture;
            end else begin
              rd_err_q   <= 1'b0;
              mem_addr_q <= req_addr_in;
              ready_q    <= 1'b0;
              state_q    <= StRdIssue;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        StWr: begin
          // Memory commits on this edge; drop the strobe after a single cycle.
          mem_rw_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= StIdle;
        end
        StRdIssue: begin
          state_q <= StRdCapture;
        end
        StRdCapture: begin
          rsp_data_q  <= rd_err_q ? '0 : mem_data_in;
          rsp_err_q   <= rd_err_q;
          rsp_valid_q <= 1'b1;
          rd_err_q    <= 1'b0;
          state_q     <= StRsp;
        end
        StRsp: begin
          if (rsp_ready_in) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Drive ports straight from the registers.
  always_comb begin
    req_ready_out      = ready_q;
    rsp_valid_out      = rsp_valid_q;
    rsp_data_out       = rsp_data_q;
    rsp_err_out        = rsp_err_q;
    err_sticky_out     = err_sticky_q;
    mem_read_write_out = mem_rw_q;
    mem_addr_out       = mem_addr_q;
    mem_data_out       = mem_data_q;
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl with a behavioural memory cell.
module tb_mem_req_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned DS = 1024;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          req_valid_in;
  logic          req_ready_out;
  logic          req_write_in;
  logic [DW-1:0] req_addr_in;
  logic [DW-1:0] req_data_in;
  logic          rsp_valid_out;
  logic          rsp_ready_in;
  logic [DW-1:0] rsp_data_out;
  logic          rsp_err_out;
  logic          err_sticky_out;
  logic          mem_read_write_out;
  logic [DW-1:0] mem_addr_out;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;

  always #5 clk_in = ~clk_in;

  mem_req_ctrl #(
    .DATA_WIDTH(DW),
    .DATA_SIZE (DS)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .req_valid_in      (req_valid_in),
    .req_ready_out     (req_ready_out),
    .req_write_in      (req_write_in),
    .req_addr_in       (req_addr_in),
    .req_data_in       (req_data_in),
    .rsp_valid_out     (rsp_valid_out),
    .rsp_ready_in      (rsp_ready_in),
    .rsp_data_out      (rsp_data_out),
    .rsp_err_out       (rsp_err_out),
    .err_sticky_out    (err_sticky_out),
    .mem_read_write_out(mem_read_write_out),
    .mem_addr_out      (mem_addr_out),
    .mem_data_out      (mem_data_out),
    .mem_data_in       (mem_data_in)
  );

  // Single-port synchronous memory cell, 1-cycle read latency.
  logic [DW-1:0] mem_cell [DS] = '{default: '0};
  always @(posedge clk_in) begin
    if (mem_read_write_out) mem_cell[mem_addr_out[9:0]] <= mem_data_out;
    mem_data_in <= mem_cell[mem_addr_out[9:0]];
  end

  // Cycle counter, write-strobe counter, out-of-range strobe counter.
  int cyc = 0;
  int wr_pulses = 0;
  int bad_wr = 0;
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (mem_read_write_out) wr_pulses <= wr_pulses + 1;
    if (mem_read_write_out && (mem_addr_out >= DS)) bad_wr <= bad_wr + 1;
  end

  // Reference model: word array, sticky error flag, expected write count.
  logic [DW-1:0] ref_mem [DS];
  bit            ref_sticky;
  int            exp_pulses;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One request through the DUT; checks protocol invariants along the way.
  task automatic do_req(input bit wr, input logic [DW-1:0] addr, input logic [DW-1:0] data,
                        input int stall, output logic [DW-1:0] rdata, output bit rerr,
                        output int lat);
    int g;
    rdata = '0;
    rerr  = 1'b0;
    lat   = -1;
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_write_in = wr;
    req_addr_in  = addr;
    req_data_in  = data;
    g = 0;
    while (!req_ready_out && g < 50) begin
      @(negedge clk_in);
      g++;
    end
    if (g >= 50) begin
      check("accept_timeout", 64'(g), 64'd0);
      req_valid_in = 1'b0;
      return;
    end
    @(negedge clk_in);  // just after the accept edge
    req_valid_in = 1'b0;
    req_write_in = 1'($urandom);
    req_addr_in  = $urandom;
    req_data_in  = $urandom;
    if (wr) begin
      if (addr < DS) begin
        check("wr_pulse_on", 64'(mem_read_write_out), 64'd1);
        check("wr_busy", 64'(req_ready_out), 64'd0);
        @(negedge clk_in);
        check("wr_pulse_off", 64'(mem_read_write_out), 64'd0);
        check("wr_ready_again", 64'(req_ready_out), 64'd1);
        check("wr_committed", 64'(mem_cell[addr[9:0]]), 64'(data));
      end else begin
        check("oor_wr_no_pulse", 64'(mem_read_write_out), 64'd0);
        check("oor_wr_ready", 64'(req_ready_out), 64'd1);
      end
      lat = 0;
    end else begin
      lat = 0;
      while (!rsp_valid_out && lat < 20) begin
        check("rd_busy", 64'(req_ready_out), 64'd0);
        rsp_ready_in = 1'($urandom);  // ignored while no response
        @(negedge clk_in);
        lat++;
      end
      rsp_ready_in = 1'b0;
      if (lat >= 20) begin
        check("rsp_timeout", 64'(lat), 64'd0);
        return;
      end
      rdata = rsp_data_out;
      rerr  = rsp_err_out;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk_in);
        check("stall_valid", 64'(rsp_valid_out), 64'd1);
        check("stall_data", 64'(rsp_data_out), 64'(rdata));
        check("stall_err", 64'(rsp_err_out), 64'(rerr));
        check("stall_ready", 64'(req_ready_out), 64'd0);
      end
      rsp_ready_in = 1'b1;
      @(negedge clk_in);
      rsp_ready_in = 1'b0;
      check("rsp_dropped", 64'(rsp_valid_out), 64'd0);
      check("idle_after_rsp", 64'(req_ready_out), 64'd1);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
    bit          exp_sticky;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [DW-1:0] rd;
    bit            er;
    int            lat;
    int            acc[16];
    int            i;
    int            g;
    bit            seen;

    for (int k = 0; k < int'(DS); k++) ref_mem[k] = '0;
    ref_sticky   = 1'b0;
    exp_pulses   = 0;
    rst_n_in     = 1'b0;
    req_valid_in = 1'b0;
    req_write_in = 1'b0;
    req_addr_in  = '0;
    req_data_in  = '0;
    rsp_ready_in = 1'b0;

    // Reset held over edges with random inputs.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      req_valid_in = 1'($urandom);
      req_write_in = 1'($urandom);
      req_addr_in  = $urandom_range(0, 31);
      req_data_in  = $urandom;
      rsp_ready_in = 1'($urandom);
      check("rst_ctrl", 64'({req_ready_out, rsp_valid_out, rsp_err_out, err_sticky_out,
                             mem_read_write_out}), 64'd0);
      check("rst_data", 64'({rsp_data_out, mem_addr_out}), 64'd0);
      check("rst_mem_data", 64'(mem_data_out), 64'd0);
    end
    @(negedge clk_in);
    req_valid_in = 1'b0;
    rsp_ready_in = 1'b0;
    rst_n_in     = 1'b1;
    check("ready_before_edge", 64'(req_ready_out), 64'd0);
    @(negedge clk_in);
    check("ready_after_release", 64'(req_ready_out), 64'd1);
    check("no_pulse_in_reset", 64'(wr_pulses), 64'd0);

    // Directed vectors: basic write/read, range boundaries, backpressure.
    vecs[0] = '{1'b1, 32'd5,          32'hDEADBEEF, 0,  32'h0,        1'b0, 0, 1'b0};
    vecs[1] = '{1'b0, 32'd5,          32'h0,        0,  32'hDEADBEEF, 1'b0, 2, 1'b0};
    vecs[2] = '{1'b1, 32'd1023,       32'hA5A5A5A5, 0,  32'h0,        1'b0, 0, 1'b0};
    vecs[3] = '{1'b0, 32'd1024,       32'h0,        0,  32'h0,        1'b1, 1, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFFFFFF,   32'h12345678, 0,  32'h0,        1'b0, 0, 1'b1};
    vecs[5] = '{1'b0, 32'd1023,       32'h0,        0,  32'hA5A5A5A5, 1'b0, 2, 1'b1};
    vecs[6] = '{1'b0, 32'd5,          32'h0,        10, 32'hDEADBEEF, 1'b0, 2, 1'b1};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'h0,        3,  32'h0,        1'b1, 1, 1'b1};
    vecs[8] = '{1'b1, 32'd1024,       32'h55AA55AA, 0,  32'h0,        1'b0, 0, 1'b1};
    vecs[9] = '{1'b0, 32'd0,          32'h0,        1,  32'h0,        1'b0, 2, 1'b1};
    for (int v = 0; v < 10; v++) begin
      do_req(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].stall, rd, er, lat);
      if (!vecs[v].wr) begin
        check($sformatf("vec%0d_data", v), 64'(rd), 64'(vecs[v].exp_data));
        check($sformatf("vec%0d_err", v), 64'(er), 64'(vecs[v].exp_err));
        check($sformatf("vec%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
      end
      check($sformatf("vec%0d_sticky", v), 64'(err_sticky_out), 64'(vecs[v].exp_sticky));
      if (vecs[v].wr && vecs[v].addr < DS) begin
        ref_mem[vecs[v].addr[9:0]] = vecs[v].data;
        exp_pulses++;
      end else if (vecs[v].wr) begin
        ref_sticky = 1'b1;
      end
    end

    // Back-to-back writes with valid held high: one accept every second cycle.
    @(negedge clk_in);
    i = 0;
    g = 0;
    req_valid_in = 1'b1;
    req_write_in = 1'b1;
    req_addr_in  = 32'd0;
    req_data_in  = 32'hB000_0000;
    while (i < 16 && g < 100) begin
      if (req_ready_out) begin
        acc[i] = cyc;
        @(negedge clk_in);
        i++;
        req_addr_in = 32'(i);
        req_data_in = 32'hB000_0000 + 32'(i) * 32'h0101_0101;
      end else begin
        @(negedge clk_in);
      end
      g++;
    end
    req_valid_in = 1'b0;
    check("b2b_accepts", 64'(i), 64'd16);
    for (int k = 1; k < i; k++) check($sformatf("b2b_gap%0d", k), 64'(acc[k] - acc[k-1]), 64'd2);
    for (int k = 0; k < i; k++) begin
      ref_mem[k] = 32'hB000_0000 + 32'(k) * 32'h0101_0101;
      exp_pulses++;
    end
    for (int k = 0; k < 16; k++) begin
      do_req(1'b0, 32'(k), 32'h0, 0, rd, er, lat);
      check($sformatf("b2b_rd%0d", k), 64'(rd), 64'(ref_mem[k]));
    end

    // Reset during RD_ISSUE: response is lost, sticky error clears.
    check("sticky_before_rst", 64'(err_sticky_out), 64'(ref_sticky));
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_write_in = 1'b0;
    req_addr_in  = 32'd5;
    @(negedge clk_in);  // ready was high, accept edge has passed
    req_valid_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    check("rst_rd_async", 64'({req_ready_out, rsp_valid_out, err_sticky_out,
                               mem_read_write_out}), 64'd0);
    @(negedge clk_in);
    rst_n_in   = 1'b1;
    ref_sticky = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      seen |= rsp_valid_out;
    end
    check("rst_rd_no_rsp", 64'(seen), 64'd0);
    check("sticky_cleared", 64'(err_sticky_out), 64'd0);

    // Reset during WR: the pending write must not land.
    do_req(1'b1, 32'd9, 32'h1111_1111, 0, rd, er, lat);
    ref_mem[9] = 32'h1111_1111;
    exp_pulses++;
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_write_in = 1'b1;
    req_addr_in  = 32'd9;
    req_data_in  = 32'h2222_2222;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    check("rst_wr_pulse_before", 64'(mem_read_write_out), 64'd1);
    rst_n_in = 1'b0;
    #1;
    check("rst_wr_pulse_killed", 64'(mem_read_write_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("rst_wr_ready", 64'(req_ready_out), 64'd1);
    check("rst_wr_not_committed", 64'(mem_cell[9]), 64'h1111_1111);
    do_req(1'b0, 32'd9, 32'h0, 0, rd, er, lat);
    check("rst_wr_readback", 64'(rd), 64'h1111_1111);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      bit            wr;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
      int            sel;
      wr   = 1'($urandom);
      data = $urandom;
      sel  = $urandom_range(0, 9);
      if (sel < 7)       addr = $urandom_range(0, 31);
      else if (sel == 7) addr = 32'd1023;
      else if (sel == 8) addr = 32'd1024;
      else               addr = $urandom | 32'h0000_0400;
      do_req(wr, addr, data, $urandom_range(0, 3), rd, er, lat);
      if (wr) begin
        if (addr < DS) begin
          ref_mem[addr[9:0]] = data;
          exp_pulses++;
        end else begin
          ref_sticky = 1'b1;
        end
      end else begin
        check("rnd_data", 64'(rd), (addr < DS) ? 64'(ref_mem[addr[9:0]]) : 64'd0);
        check("rnd_err", 64'(er), (addr < DS) ? 64'd0 : 64'd1);
        check("rnd_lat", 64'(lat), (addr < DS) ? 64'd2 : 64'd1);
      end
      check("rnd_sticky", 64'(err_sticky_out), 64'(ref_sticky));
    end

    @(negedge clk_in);
    check("write_pulse_count", 64'(wr_pulses), 64'(exp_pulses));
    check("no_oor_strobe", 64'(bad_wr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
